// File: rtl/i2c_slave_ctrl_if.sv
// Handshake bundle between the I2C slave control FSM and its datapath:
// detector/counter status in, per-cycle enables and strobes out.
interface i2c_slave_ctrl_if;
  logic start;
  logic stop;
  logic SCL_posedge;
  logic SCL_negedge;
  logic count_done;
  logic addr_valid;
  logic rw_bit;
  logic ack_in;
  logic clear_start;
  logic clear_stop;
  logic count_clear;
  logic count_en;
  logic shift_en;
  logic reg_load;
  logic reg_inc;
  logic mem_we;
  logic send_ack;
  logic out_en;
  logic busy;
  logic timeout_err;

  modport slave (
    input  start, stop, SCL_posedge, SCL_negedge, count_done, addr_valid, rw_bit, ack_in,
    output clear_start, clear_stop, count_clear, count_en, shift_en, reg_load,
           reg_inc, mem_we, send_ack, out_en, busy, timeout_err
  );

  modport master (
    output start, stop, SCL_posedge, SCL_negedge, count_done, addr_valid, rw_bit, ack_in,
    input  clear_start, clear_stop, count_clear, count_en, shift_en, reg_load,
           reg_inc, mem_we, send_ack, out_en, busy, timeout_err
  );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// I2C slave control FSM: sequences address, register-pointer and data bytes,
// drives datapath enables/strobes and aborts stalled transfers on timeout.
module i2c_slave_ctrl #(
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned TW      = 17
) (
  input logic              clock,
  input logic              reset_n,
  i2c_slave_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
  } state_t;

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic          rw_q, rw_nx;
  logic [TW-1:0] to_cnt;
  logic          clear_start_q, clear_stop_q, count_clear_q, timeout_err_q;
  logic          start_hit, stop_hit, timeout_hit, entry_clear;
  logic          reg_load, mem_we, reg_inc;

  // A flag whose clear is already in flight is the same event, not a new one.
  assign start_hit   = bus.start & ~clear_start_q;
  assign stop_hit    = bus.stop & ~clear_stop_q;
  assign timeout_hit = (TIMEOUT != 0) && (state != IDLE) && (to_cnt == TO_LAST);
  assign entry_clear = (state_nx != state) &&
                       (state_nx == REG || state_nx == WRITE || state_nx == READ);

  always_comb begin
    state_nx = state;
    rw_nx    = rw_q;
    reg_load = 1'b0;
    mem_we   = 1'b0;
    reg_inc  = 1'b0;
    if (timeout_hit || stop_hit) begin
      state_nx = IDLE;
    end else if (start_hit) begin
      state_nx = ADDR;
    end else begin
      case (state)
        ADDR:
          if (bus.SCL_negedge && bus.count_done) begin
            if (bus.addr_valid) begin
              state_nx = ADDR_ACK;
              rw_nx    = bus.rw_bit;
            end else begin
              state_nx = WAIT_STOP;
            end
          end
        ADDR_ACK:
          if (bus.SCL_negedge) state_nx = rw_q ? READ : REG;
        REG:
          if (bus.SCL_negedge && bus.count_done) begin
            reg_load = 1'b1;
            state_nx = REG_ACK;
          end
        REG_ACK:
          if (bus.SCL_negedge) state_nx = WRITE;
        WRITE:
          if (bus.SCL_negedge && bus.count_done) begin
            mem_we   = 1'b1;
            state_nx = WRITE_ACK;
          end
        WRITE_ACK:
          if (bus.SCL_negedge) begin
            reg_inc  = 1'b1;
            state_nx = WRITE;
          end
        READ:
          if (bus.SCL_negedge && bus.count_done) state_nx = READ_ACK;
        READ_ACK:
          if (bus.SCL_negedge) begin
            if (bus.ack_in) begin
              reg_inc  = 1'b1;
              state_nx = READ;
            end else begin
              state_nx = WAIT_STOP;
            end
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      rw_q          <= 1'b0;
      to_cnt        <= '0;
      clear_start_q <= 1'b0;
      clear_stop_q  <= 1'b0;
      count_clear_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state         <= state_nx;
      rw_q          <= rw_nx;
      clear_stop_q  <= ~timeout_hit & stop_hit;
      clear_start_q <= ~timeout_hit & ~stop_hit & start_hit;
      count_clear_q <= timeout_hit | (~stop_hit & start_hit) | entry_clear;
      timeout_err_q <= timeout_hit;
      if (state == IDLE || bus.SCL_posedge || bus.SCL_negedge ||
          bus.start || bus.stop || timeout_hit)
        to_cnt <= '0;
      else if (to_cnt != '1)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  assign bus.clear_start = clear_start_q;
  assign bus.clear_stop  = clear_stop_q;
  assign bus.count_clear = count_clear_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.reg_load    = reg_load;
  assign bus.mem_we      = mem_we;
  assign bus.reg_inc     = reg_inc;
  assign bus.count_en    = bus.SCL_posedge & ~bus.count_done &
                           (state == ADDR || state == REG || state == WRITE || state == READ);
  assign bus.shift_en    = (state == ADDR || state == REG || state == WRITE);
  assign bus.send_ack    = (state == ADDR_ACK || state == REG_ACK || state == WRITE_ACK);
  assign bus.out_en      = (state == READ);
  assign bus.busy        = (state != IDLE);

endmodule
